// File: rtl/mem_io_responder.sv
// mem_io_responder: data memory and MMIO responder for a single-issue core.
// Decodes addr[31:28] into DMEM (4'h1) and MMIO (4'h8) regions. DMEM is a
// byte-writable word array. MMIO provides FIFO status, a TX byte FIFO push
// port, a free-running cycle counter, a retired-instruction counter and a
// counter clear. Loads return registered data one cycle after re.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   addr           core byte address for loads and stores
//   wdata          lane-aligned store data
//   wea            per-byte write enables; nonzero marks a store
//   re             load request
//   rdata          registered load data
//   instr_retired  one pulse per retired instruction
//   tx_data        byte at the TX FIFO head
//   tx_valid       TX FIFO non-empty
//   tx_ready       sink ready; pop when tx_valid && tx_ready
module mem_io_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DMEM_AW   = 12,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wea,
  input  logic            re,
  output logic [XLEN-1:0] rdata,
  input  logic            instr_retired,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam int unsigned DMEM_WORDS = 1 << DMEM_AW;
  localparam int unsigned LANES      = 4;
  localparam int unsigned PW         = $clog2(TXQ_DEPTH);
  localparam int unsigned CW         = PW + 1;

  localparam logic [3:0]  SEG_DMEM   = 4'h1;
  localparam logic [3:0]  SEG_MMIO   = 4'h8;
  localparam logic [27:0] OFF_STATUS = 28'h000_0000;
  localparam logic [27:0] OFF_TXDATA = 28'h000_0008;
  localparam logic [27:0] OFF_CYCLE  = 28'h000_0010;
  localparam logic [27:0] OFF_INSTR  = 28'h000_0014;
  localparam logic [27:0] OFF_CLEAR  = 28'h000_0018;

  // Address decode
  logic [3:0]         seg;
  logic [27:0]        off;
  logic [DMEM_AW-1:0] dmem_idx;
  logic               sel_dmem;
  logic               sel_mmio;
  logic               is_store;

  assign seg      = addr[31:28];
  assign off      = addr[27:0];
  assign dmem_idx = addr[DMEM_AW+1:2];
  assign sel_dmem = (seg == SEG_DMEM);
  assign sel_mmio = (seg == SEG_MMIO);
  assign is_store = |wea;

  // Data memory: byte-lane writes, contents survive reset
  logic [XLEN-1:0] dmem [DMEM_WORDS];

  always_ff @(posedge clk) begin
    if (sel_dmem && is_store) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wea[i]) dmem[dmem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Performance counters
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instr_cnt;
  logic            cnt_clear;

  assign cnt_clear = sel_mmio && (off == OFF_CLEAR) && is_store;

  // Clear wins over increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (cnt_clear) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + XLEN'(1);
      if (instr_retired) instr_cnt <= instr_cnt + XLEN'(1);
    end
  end

  // TX FIFO
  logic [7:0]    fifo_mem [TXQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [7:0]    head_n;

  assign fifo_full  = (count == CW'(TXQ_DEPTH));
  assign fifo_empty = (count == '0);
  assign push_req   = sel_mmio && (off == OFF_TXDATA) && wea[0];
  // Full is judged before any same-cycle pop, so a push on full is lost
  assign push_ok    = push_req && !fifo_full;
  assign pop_ok     = tx_valid && tx_ready && !fifo_empty;

  // Next-state pointers, occupancy and head byte
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (push_ok) wr_ptr_n = wr_ptr + PW'(1);
    if (pop_ok)  rd_ptr_n = rd_ptr + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
    // The byte being written this cycle becomes head when it lands on rd_ptr_n
    if (push_ok && (wr_ptr == rd_ptr_n)) head_n = wdata[7:0];
    else                                 head_n = fifo_mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      tx_valid <= (count_n != '0);
      if (count_n != '0) tx_data <= head_n;
    end
  end

  // Load path: pre-edge state captured one cycle after re
  logic [XLEN-1:0] rd_value;

  always_comb begin
    rd_value = '0;
    if (sel_dmem) begin
      rd_value = dmem[dmem_idx];
    end else if (sel_mmio) begin
      case (off)
        OFF_STATUS: rd_value = XLEN'({fifo_empty, fifo_full});
        OFF_CYCLE:  rd_value = cycle_cnt;
        OFF_INSTR:  rd_value = instr_cnt;
        default:    rd_value = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rd_value;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wea;
  logic        re;
  logic [31:0] rdata;
  logic        instr_retired;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks;
  int failures;
  logic [7:0] exp_q [$];

  mem_io_responder #(.XLEN(32), .DMEM_AW(12), .TXQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .wea           (wea),
    .re            (re),
    .rdata         (rdata),
    .instr_retired (instr_retired),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle, then return the bus to idle
  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic r);
    addr  = a;
    wdata = d;
    wea   = w;
    re    = r;
    tick();
    addr  = '0;
    wdata = '0;
    wea   = '0;
    re    = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    drive(32'h8000_0008, 32'(b), 4'h1, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    addr = '0;
    wdata = '0;
    wea = '0;
    re = 1'b0;
    instr_retired = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();
    check("reset_rdata", rdata, 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);

    // Cycle counter goes 0 -> 1 on the first edge after reset release
    rst = 1'b0;
    addr = 32'h8000_0010;
    re = 1'b1;
    tick();
    check("cycle_first_edge", rdata, 32'h0);
    tick();
    check("cycle_second_edge", rdata, 32'h1);
    re = 1'b0;
    addr = '0;

    // Byte-enable stores
    drive(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    drive(32'h1000_0010, 32'h0000_00AA, 4'h1, 1'b0);
    drive(32'h1000_0010, 32'h0, 4'h0, 1'b1);
    check("dmem_partial_store", rdata, 32'hDEAD_BEAA);
    tick();
    check("rdata_hold", rdata, 32'hDEAD_BEAA);
    drive(32'h1000_0012, 32'h1200_0000, 4'h8, 1'b0);
    drive(32'h1000_0013, 32'h0, 4'h0, 1'b1);
    check("dmem_lane3_low_bits_ignored", rdata, 32'h12AD_BEAA);

    // Read-before-write
    drive(32'h1000_0010, 32'h1122_3344, 4'hF, 1'b1);
    check("rbw_old_word", rdata, 32'h12AD_BEAA);
    drive(32'h1000_0010, 32'h0, 4'h0, 1'b1);
    check("rbw_new_word", rdata, 32'h1122_3344);

    // Unmapped region aliases the same word index but must not touch DMEM
    drive(32'h2000_0010, 32'h5555_5555, 4'hF, 1'b0);
    drive(32'h2000_0010, 32'h0, 4'h0, 1'b1);
    check("unmapped_read", rdata, 32'h0);
    drive(32'h1000_0010, 32'h0, 4'h0, 1'b1);
    check("unmapped_store_ignored", rdata, 32'h1122_3344);
    drive(32'h8000_0004, 32'h0, 4'h0, 1'b1);
    check("mmio_hole_read", rdata, 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("status_empty", rdata, 32'h2);

    // Fill to full with sink stalled, fifth byte dropped
    push(8'h41);
    check("first_push_valid", 32'(tx_valid), 32'h1);
    check("first_push_data", 32'(tx_data), 32'h41);
    push(8'h42);
    push(8'h43);
    push(8'h44);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("status_full", rdata, 32'h1);
    push(8'h45);
    check("stalled_head_stable", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      tick();
    end
    check("drained_empty", 32'(tx_valid), 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("status_after_drain", rdata, 32'h2);

    // Push on full with a same-cycle pop is still dropped
    tx_ready = 1'b0;
    push(8'h60);
    push(8'h61);
    push(8'h62);
    push(8'h63);
    tx_ready = 1'b1;
    push(8'h64);
    for (int i = 0; i < 3; i++) begin
      check("full_pop_data", 32'(tx_data), 32'h61 + 32'(i));
      tick();
    end
    check("full_pop_empty", 32'(tx_valid), 32'h0);

    // Half-full streaming: one push and one pop per cycle
    tx_ready = 1'b0;
    push(8'h50);
    push(8'h51);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h51);
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", 32'(tx_valid), 32'h1);
      check("stream_data", 32'(tx_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      exp_q.push_back(8'h52 + 8'(i));
      push(8'h52 + 8'(i));
    end
    tx_ready = 1'b0;
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("stream_status_mid", rdata, 32'h0);
    tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("stream_tail_data", 32'(tx_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      tick();
    end
    check("stream_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Retired-instruction counter and clear precedence
    instr_retired = 1'b1;
    repeat (10) tick();
    instr_retired = 1'b0;
    drive(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    check("instr_count_10", rdata, 32'd10);
    instr_retired = 1'b1;
    drive(32'h8000_0018, 32'h0, 4'h4, 1'b0);
    instr_retired = 1'b0;
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cycle_after_clear", rdata, 32'h0);
    drive(32'h8000_0014, 32'h0, 4'h0, 1'b1);
    check("instr_after_clear", rdata, 32'h0);
    drive(32'h8000_0010, 32'h0, 4'h0, 1'b1);
    check("cycle_resumes", rdata, 32'h2);

    // Reset during a load and a partial fill
    drive(32'h1000_0040, 32'hCAFE_F00D, 4'hF, 1'b0);
    push(8'h77);
    push(8'h78);
    drive(32'h1000_0040, 32'h0, 4'h0, 1'b1);
    check("pre_reset_load", rdata, 32'hCAFE_F00D);
    addr = 32'h1000_0040;
    re = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("mid_reset_rdata", rdata, 32'h0);
    check("mid_reset_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_reset_tx_data", 32'(tx_data), 32'h0);
    tick();
    rst = 1'b0;
    re = 1'b0;
    addr = '0;
    check("post_reset_rdata", rdata, 32'h0);
    drive(32'h8000_0000, 32'h0, 4'h0, 1'b1);
    check("post_reset_status", rdata, 32'h2);
    drive(32'h1000_0040, 32'h0, 4'h0, 1'b1);
    check("dmem_survives_reset", rdata, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data and address width.
REQ-002 Parameter DMEM_AW, default 12, SHALL set the data memory word-address width (4096 words).
REQ-003 Parameter TXQ_DEPTH, default 4 (power of two), SHALL set the TX FIFO depth.
REQ-004 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 addr  input  XLEN  SHALL be the core byte address for load and store.
REQ-007 wdata  input  XLEN  SHALL be the store data, already lane-aligned by the core.
REQ-008 wea  input  4  SHALL be the per-byte write enables; a nonzero value marks a store.
REQ-009 re  input  1  SHALL mark a load request.
REQ-010 rdata  output  XLEN  SHALL be the registered load data returned to the core.
REQ-011 instr_retired  input  1  SHALL pulse once per retired instruction.
REQ-012 tx_data  output  8  SHALL be the byte at the TX FIFO head.
REQ-013 tx_valid  output  1  SHALL be high while the TX FIFO is non-empty.
REQ-014 tx_ready  input  1  SHALL be the sink handshake; a pop occurs when tx_valid and tx_ready are both high.

Function
REQ-015 The block SHALL decode addr[31:28]: 4'h1 selects DMEM, 4'h8 selects MMIO, and any other value SHALL read 0 and ignore writes.
REQ-016 DMEM SHALL be indexed by addr[DMEM_AW+1:2]; addr[1:0] SHALL be ignored.
REQ-017 A DMEM store SHALL write only the bytes whose wea bit is set, in the same clk edge.
REQ-018 A load SHALL have latency 1: rdata is updated on the edge after re is sampled high.
REQ-019 rdata SHALL hold its value while re is low.
REQ-020 When re and wea are both active at the same address, rdata SHALL return the old data (read-before-write).
REQ-021 MMIO offsets SHALL be as follows:
- 0x00 status (read-only): bit0 = FIFO full, bit1 = FIFO empty, upper bits 0.
- 0x08 TX data (write): wea[0] pushes wdata[7:0].
- 0x10 cycle counter (read-only).
- 0x14 retired-instruction counter (read-only).
- 0x18 counter clear (write): any nonzero wea clears both counters.
- Any other offset SHALL read 0 and ignore writes.
REQ-022 The cycle counter SHALL increment by 1 every clk cycle and wrap from 0xFFFFFFFF to 0.
REQ-023 The instruction counter SHALL increment by 1 on each cycle instr_retired is high and wrap the same way.
REQ-024 A counter clear SHALL take precedence over an increment in the same cycle; the counter reads 0 on the next cycle.
REQ-025 The TX FIFO SHALL use circular read/write pointers plus an occupancy count of 0..TXQ_DEPTH, with wrap-around at TXQ_DEPTH.
REQ-026 A push while the FIFO is full SHALL be dropped, even if a pop occurs in the same cycle; full is evaluated before the pop.
REQ-027 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve byte order.
REQ-028 A push to an empty FIFO SHALL raise tx_valid on the next cycle, with tx_data equal to the pushed byte.
REQ-029 tx_data SHALL remain stable while tx_valid is high and tx_ready is low.
REQ-030 Status reads SHALL return the pre-edge FIFO state, registered with 1-cycle latency as in REQ-018.

Reset
REQ-031 On rst SHALL set: rdata=0, tx_valid=0, tx_data=0, both counters=0, FIFO pointers and count=0.
REQ-032 DMEM contents SHALL NOT be reset.
REQ-033 An assertion of rst mid-load SHALL discard the pending read result; rdata=0.
REQ-034 On the first edge after rst deasserts, the cycle counter SHALL go 0 -> 1.

Verification
REQ-035 Store 0xDEADBEEF to 0x10000010 with wea=4'hF, then store 0x000000AA with wea=4'h1, then load 0x10000010 -> rdata=0xDEADBEAA one cycle after re.
REQ-036 Load 0x10000010 and store to it in the same cycle -> rdata returns the old word; a subsequent load returns the new word.
REQ-037 With tx_ready=0, push 0x41..0x45 -> status=0x1 after the 4th push, the 5th byte is dropped, and 0x41, 0x42, 0x43, 0x44 drain in order when tx_ready=1.
REQ-038 With the FIFO half-full and tx_ready=1, push one byte per cycle -> count is constant and no bytes are lost or reordered.
REQ-039 Pulse instr_retired for 10 cycles, then write 0x18 while instr_retired=1 -> the counter reads 10 before the write and 0 after it.
REQ-040 Assert rst during a load and during a FIFO fill -> all outputs 0, status=0x2, and an earlier DMEM store is still readable.
